// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one request/grant/response bus transaction per
// load or store. Misaligned and illegal requests are rejected without a bus cycle.
module mem_access_unit #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    output logic              stall_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              load_valid_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [XLEN-1:0]   bus_addr_o,
    output logic [XLEN-1:0]   bus_wdata_o,
    output logic [XLEN/8-1:0] bus_wstrb_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [XLEN-1:0]   bus_rdata_i
);

    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e      state;
    logic        isLoad;
    logic [2:0]  funct3Reg;
    logic [2:0]  offReg;

    logic              reqPresent;
    logic              illegal;
    logic              misaligned;
    logic [2:0]        off;
    logic [1:0]        accessSize;
    logic [3:0]        accessBytes;
    logic [NB-1:0]     strobeNext;
    logic [XLEN-1:0]   wdataNext;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   extended;

    assign off         = addr_i[2:0];
    assign accessSize  = funct3_i[1:0];
    assign accessBytes = 4'd1 << accessSize;
    assign reqPresent  = mem_read_i | mem_write_i;
    assign illegal     = (mem_read_i & mem_write_i)
                       | (mem_read_i & (funct3_i == 3'b111))
                       | (mem_write_i & funct3_i[2]);

    always_comb begin
        misaligned = 1'b0;
        case (accessSize)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off[1:0] != 2'd0);
            default: misaligned = (off != 3'd0);
        endcase
    end

    // A lane is enabled when it falls inside [off, off + accessBytes).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : gen_strobe
            assign strobeNext[gi] = (4'(gi) >= {1'b0, off})
                                 && (4'(gi) < ({1'b0, off} + accessBytes));
        end
    endgenerate

    assign wdataNext = store_data_i << {off, 3'b000};
    assign shifted   = bus_rdata_i >> {offReg, 3'b000};

    always_comb begin
        extended = shifted;
        case (funct3Reg)
            3'b000:  extended = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  extended = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  extended = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  extended = {{(XLEN-8){1'b0}},  shifted[7:0]};
            3'b101:  extended = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  extended = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: extended = shifted;
        endcase
    end

    assign stall_o = (state == REQ) || (state == WAIT) || ((state == IDLE) && reqPresent);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            isLoad       <= 1'b0;
            funct3Reg    <= 3'b000;
            offReg       <= 3'b000;
            load_data_o  <= '0;
            load_valid_o <= 1'b0;
            err_o        <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_wstrb_o  <= '0;
        end else begin
            load_valid_o <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqPresent) begin
                        if (illegal || misaligned) begin
                            err_o <= 1'b1;
                            state <= DONE;
                        end else begin
                            isLoad      <= mem_read_i;
                            funct3Reg   <= funct3_i;
                            offReg      <= off;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_write_i;
                            bus_addr_o  <= {addr_i[XLEN-1:3], 3'b000};
                            bus_wstrb_o <= mem_write_i ? strobeNext : '0;
                            bus_wdata_o <= mem_write_i ? wdataNext : '0;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state     <= isLoad ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        load_data_o  <= extended;
                        load_valid_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
